// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
package shifter_pkg;

   typedef enum logic [1:0] {
      MODE_LSL = 2'b00,
      MODE_LSR = 2'b01,
      MODE_ASR = 2'b10,
      MODE_ROR = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Bits needed to hold a per-iteration shift amount of 0..step.
   function automatic int step_amt_w(input int step);
      return $clog2(step + 1);
   endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational iteration of the shifter: shifts by 0..STEP positions.
// ROR is only built when ITER_SHIFTER_ROTATE_EN is defined; otherwise MODE_ROR passes data through.
module shift_step
   import shifter_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  STEP  = 1,
   localparam int SA_W  = step_amt_w(STEP)
) (
   input  logic [WIDTH-1:0] data,
   input  mode_t            mode,
   input  logic [SA_W-1:0]  amount,
   input  logic             sign,
   output logic [WIDTH-1:0] shifted
);

   logic [WIDTH-1:0] fill_mask;

   // Ones in the MSB positions vacated by a right shift of this iteration.
   assign fill_mask = ~({WIDTH{1'b1}} >> amount);

   always_comb begin
      shifted = data;
      case (mode)
         MODE_LSL: shifted = data << amount;
         MODE_LSR: shifted = data >> amount;
         MODE_ASR: shifted = (data >> amount) | (sign ? fill_mask : '0);
         MODE_ROR: begin
`ifdef ITER_SHIFTER_ROTATE_EN
            shifted = (data >> amount) | (data << (WIDTH - int'(amount)));
`else
            shifted = data;
`endif
         end
         default:  shifted = data;
      endcase
   end

endmodule

// File: rtl/iter_shifter.sv
// Iterative barrel-shifter replacement: shifts by up to STEP bits per clock.
// Define ITER_SHIFTER_ROTATE_EN to enable ROR; otherwise ROR requests complete unshifted with OUT_ERR set.
module iter_shifter
   import shifter_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  STEP  = 1,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [1:0]       MODE,
   input  logic [AMT_W-1:0] AMT,
   input  logic [WIDTH-1:0] INPUT,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUTPUT,
   output logic             OUT_ERR
);

   localparam int SA_W = step_amt_w(STEP);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] work;
   logic [AMT_W-1:0] rem;
   logic [AMT_W-1:0] load_rem;
   mode_t            mode_q;
   logic             sign_q;
   logic [SA_W-1:0]  step_amt;
   logic [WIDTH-1:0] stepped;
   logic             accept;
   logic             advance;

   assign accept  = IN_VALID && (state == ST_IDLE);
   assign advance = (state == ST_SHIFT) && (rem != '0);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (IN_VALID)   state_nxt = ST_SHIFT;
         ST_SHIFT: if (rem == '0)  state_nxt = ST_DONE;
         ST_DONE:  if (OUT_READY)  state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   // Each iteration moves min(STEP, rem) positions.
   always_comb begin
      if (rem >= AMT_W'(STEP)) begin
         step_amt = SA_W'(STEP);
      end else begin
         step_amt = SA_W'(rem);
      end
   end

`ifdef ITER_SHIFTER_ROTATE_EN
   assign load_rem = AMT;
`else
   // Unsupported rotate behaves like a zero-length shift.
   assign load_rem = (mode_t'(MODE) == MODE_ROR) ? '0 : AMT;
`endif

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .data    (work),
      .mode    (mode_q),
      .amount  (step_amt),
      .sign    (sign_q),
      .shifted (stepped)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         work   <= '0;
         rem    <= '0;
         mode_q <= MODE_LSL;
         sign_q <= 1'b0;
      end else if (accept) begin
         work   <= INPUT;
         rem    <= load_rem;
         mode_q <= mode_t'(MODE);
         sign_q <= INPUT[WIDTH-1];
      end else if (advance) begin
         work   <= stepped;
         rem    <= rem - AMT_W'(step_amt);
      end
   end

`ifdef ITER_SHIFTER_ROTATE_EN
   assign OUT_ERR = 1'b0;
`else
   logic err_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= (mode_t'(MODE) == MODE_ROR);
      end
   end

   assign OUT_ERR = err_q && (state == ST_DONE);
`endif

   assign IN_READY  = (state == ST_IDLE);
   assign OUT_VALID = (state == ST_DONE);
   assign OUTPUT    = work;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: one instance with STEP=1 (sel 0), one with STEP=4 (sel 1).
module tb_iter_shifter;

`ifdef ITER_SHIFTER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   typedef struct {
      bit          sel;
      logic [1:0]  mode;
      int          amt;
      logic [31:0] din;
      logic [31:0] q;
      logic        err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic        err;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   vec_t vt[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v1, r1, ov1, or1, e1;
   logic [1:0]  m1;
   logic [4:0]  a1;
   logic [31:0] d1, q1;
   logic        v4, r4, ov4, or4, e4;
   logic [1:0]  m4;
   logic [4:0]  a4;
   logic [31:0] d4, q4;

   always #5 clk = ~clk;

   iter_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(v1), .IN_READY(r1), .MODE(m1), .AMT(a1),
      .INPUT(d1), .OUT_VALID(ov1), .OUT_READY(or1), .OUTPUT(q1), .OUT_ERR(e1)
   );

   iter_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(v4), .IN_READY(r4), .MODE(m4), .AMT(a4),
      .INPUT(d4), .OUT_VALID(ov4), .OUT_READY(or4), .OUTPUT(q4), .OUT_ERR(e4)
   );

   function automatic logic get_rdy(input bit sel);
      return sel ? r4 : r1;
   endfunction

   function automatic logic get_ov(input bit sel);
      return sel ? ov4 : ov1;
   endfunction

   function automatic logic [31:0] get_q(input bit sel);
      return sel ? q4 : q1;
   endfunction

   function automatic logic get_err(input bit sel);
      return sel ? e4 : e1;
   endfunction

   function automatic logic [31:0] model_q(input logic [1:0] m, input int amt, input logic [31:0] x);
      logic signed [31:0] sx;
      sx = x;
      case (m)
         2'd0:    return x << amt;
         2'd1:    return x >> amt;
         2'd2:    return 32'(sx >>> amt);
         default: return ROT ? ((x >> amt) | (x << (32 - amt))) : x;
      endcase
   endfunction

   function automatic int model_lat(input bit sel, input logic [1:0] m, input int amt);
      int step;
      step = sel ? 4 : 1;
      if (m == 2'd3 && !ROT) return 1;
      return (amt + step - 1) / step + 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic [1:0] m, input logic [4:0] a,
                        input logic [31:0] d);
      if (sel) begin
         v4 = v; m4 = m; a4 = a; d4 = d;
      end else begin
         v1 = v; m1 = m; a1 = a; d1 = d;
      end
   endtask

   task automatic pop_compare(input bit sel, input string name);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s_sb: got result, expected none pending", name);
      end else begin
         e = sb.pop_front();
         check({name, "_q"}, get_q(sel), e.q);
         check({name, "_err"}, 32'(get_err(sel)), 32'(e.err));
      end
   endtask

   // Waits for OUT_VALID after an accepting edge; returns edges counted.
   task automatic wait_done(input bit sel, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!get_ov(sel) && n < 100);
   endtask

   // Called at a negedge with the selected DUT idle; ends at a negedge.
   task automatic run_op(input bit sel, input logic [1:0] m, input int amt, input logic [31:0] din,
                         input logic [31:0] eq, input logic eerr, input int elat, input string name);
      int n;
      check({name, "_rdy"}, 32'(get_rdy(sel)), 32'd1);
      drive(sel, 1'b1, m, 5'(amt), din);
      @(posedge clk); #1;
      sb.push_back('{eq, eerr});
      drive(sel, 1'b0, 2'($urandom), 5'($urandom), $urandom);
      check({name, "_busy"}, 32'(get_rdy(sel)), 32'd0);
      wait_done(sel, n);
      check({name, "_lat"}, 32'(n), 32'(elat));
      if (get_ov(sel)) pop_compare(sel, name);
      else sb.delete();
      @(posedge clk); #1;
      check({name, "_ovclr"}, 32'(get_ov(sel)), 32'd0);
      check({name, "_idle"}, 32'(get_rdy(sel)), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      vec_t t;
      logic [1:0] rm;
      int ra;
      bit rs;
      logic [31:0] rd;

      vt.push_back('{1'b0, 2'd0, 4,  32'h0000_00F1, 32'h0000_0F10, 1'b0, 5});
      vt.push_back('{1'b1, 2'd2, 9,  32'h8000_0000, 32'hFFC0_0000, 1'b0, 4});
      vt.push_back('{1'b1, 2'd1, 9,  32'h8000_0000, 32'h0040_0000, 1'b0, 4});
      vt.push_back('{1'b0, 2'd0, 0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1});
      vt.push_back('{1'b0, 2'd1, 0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1});
      vt.push_back('{1'b0, 2'd2, 0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1});
      vt.push_back('{1'b0, 2'd3, 0,  32'h1234_5678, 32'h1234_5678, !ROT, 1});
      vt.push_back('{1'b1, 2'd3, 8,  32'h1234_5678, ROT ? 32'h7812_3456 : 32'h1234_5678, !ROT, ROT ? 3 : 1});
      vt.push_back('{1'b0, 2'd3, 8,  32'h1234_5678, ROT ? 32'h7812_3456 : 32'h1234_5678, !ROT, ROT ? 9 : 1});
      vt.push_back('{1'b1, 2'd0, 31, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 9});
      vt.push_back('{1'b0, 2'd2, 31, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 32});
      vt.push_back('{1'b1, 2'd2, 5,  32'h7000_0000, 32'h0380_0000, 1'b0, 3});
      vt.push_back('{1'b1, 2'd3, 1,  32'h0000_0001, ROT ? 32'h8000_0000 : 32'h0000_0001, !ROT, ROT ? 2 : 1});
      vt.push_back('{1'b1, 2'd1, 3,  32'h0000_00F0, 32'h0000_001E, 1'b0, 2});

      rst_n = 1'b0;
      or1 = 1'b1;
      or4 = 1'b1;
      drive(1'b0, 1'b0, 2'd0, 5'd0, 32'h0);
      drive(1'b1, 1'b0, 2'd0, 5'd0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check("rst_rdy", 32'(get_rdy(s[0])), 32'd1);
         check("rst_ov", 32'(get_ov(s[0])), 32'd0);
         check("rst_q", get_q(s[0]), 32'h0);
         check("rst_err", 32'(get_err(s[0])), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         t = vt[i];
         run_op(t.sel, t.mode, t.amt, t.din, t.q, t.err, t.lat, $sformatf("vec%0d", i));
      end

      // Result held while the consumer stalls; new requests are ignored.
      or1 = 1'b0;
      drive(1'b0, 1'b1, 2'd0, 5'd3, 32'h0000_00A5);
      @(posedge clk); #1;
      sb.push_back('{32'h0000_0528, 1'b0});
      drive(1'b0, 1'b1, 2'd1, 5'd7, 32'hDEAD_BEEF);
      wait_done(1'b0, n);
      check("hold_lat", 32'(n), 32'd4);
      if (ov1) pop_compare(1'b0, "hold");
      else sb.delete();
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         check("hold_ov", 32'(ov1), 32'd1);
         check("hold_rdy", 32'(r1), 32'd0);
         check("hold_q", q1, 32'h0000_0528);
      end
      @(negedge clk);
      or1 = 1'b1;
      @(posedge clk); #1;
      check("hold_rel_ov", 32'(ov1), 32'd0);
      check("hold_rel_rdy", 32'(r1), 32'd1);
      drive(1'b0, 1'b0, 2'd0, 5'd0, 32'h0);
      @(posedge clk); #1;
      check("hold_noacc", 32'(r1), 32'd1);
      @(negedge clk);

      // Asynchronous reset in the middle of a long shift discards the operation.
      drive(1'b0, 1'b1, 2'd0, 5'd31, 32'h0000_0001);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 2'd0, 5'd0, 32'h0);
      repeat (5) @(posedge clk);
      #1;
      check("mid_busy", 32'(r1), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdy", 32'(r1), 32'd1);
      check("mid_rst_ov", 32'(ov1), 32'd0);
      check("mid_rst_q", q1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ov1) seen = 1;
      end
      check("mid_no_result", 32'(seen), 32'd0);
      @(negedge clk);
      run_op(1'b0, 2'd1, 31, 32'h8000_0000, 32'h0000_0001, 1'b0, 32, "after_rst");

      for (int i = 0; i < 12; i++) begin
         rs = 1'($urandom_range(0, 1));
         rm = 2'($urandom_range(0, 3));
         ra = $urandom_range(0, 31);
         rd = $urandom;
         run_op(rs, rm, ra, rd, model_q(rm, ra, rd), (rm == 2'd3) && !ROT, model_lat(rs, rm, ra),
                $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
